// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: fetches an instruction word, resolves one level of
// indirection, and presents a one-hot opcode decode until execute completes.
module fetch_decode_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int OPC_W    = 3,
  parameter int RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  exec_done,
  input  logic                  pc_ld,
  input  logic [ADDR_W-1:0]     pc_din,
  output logic [ADDR_W-1:0]     pc,
  output logic [ADDR_W-1:0]     ar,
  output logic [DATA_W-1:0]     ir,
  output logic                  i_bit,
  output logic [2**OPC_W-1:0]   dec,
  output logic                  dec_valid,
  output logic                  busy
);

  localparam int NDEC = 2**OPC_W;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_IND, S_DEC
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ar_q, ar_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                ib_q, ib_d;
  logic                req_q, req_d;
  logic [OPC_W-1:0]    opc;

  assign opc = ir_q[ADDR_W+OPC_W-1:ADDR_W];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    ib_d    = ib_q;
    req_d   = req_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T0;
      end
      S_T0: begin
        ar_d    = pc_q;
        req_d   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        if (mem_rd_valid) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 1'b1;
          req_d   = 1'b0;
          state_d = S_T2;
        end
      end
      S_T2: begin
        ib_d = ir_q[DATA_W-1];
        ar_d = ir_q[ADDR_W-1:0];
        // opcode all-ones uses the I bit for another purpose: no indirection
        if (ir_q[DATA_W-1] && (opc != '1)) begin
          req_d   = 1'b1;
          state_d = S_IND;
        end else begin
          state_d = S_DEC;
        end
      end
      S_IND: begin
        if (mem_rd_valid) begin
          ar_d    = mem_rdata[ADDR_W-1:0];
          req_d   = 1'b0;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        if (exec_done) begin
          if (pc_ld) pc_d = pc_din;
          state_d = halt ? S_IDLE : S_T0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ar_q    <= '0;
      ir_q    <= '0;
      ib_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      ib_q    <= ib_d;
      req_q   <= req_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = ar_q;
  assign pc        = pc_q;
  assign ar        = ar_q;
  assign ir        = ir_q;
  assign i_bit     = ib_q;
  assign dec_valid = (state_q == S_DEC);
  assign busy      = (state_q != S_IDLE);
  assign dec       = dec_valid ? (NDEC'(1) << opc) : '0;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: transaction-level model driven alongside random
// stimulus, compared every cycle, plus literal checks of the worked examples.
module tb_fetch_decode_ctrl;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst, start, halt, mem_req, mem_rd_valid;
  logic          exec_done, pc_ld, i_bit, dec_valid, busy;
  logic [AW-1:0] mem_addr, pc_din, pc, ar;
  logic [DW-1:0] mem_rdata, ir;
  logic [7:0]    dec;

  fetch_decode_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .OPC_W(OW), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
    .exec_done(exec_done), .pc_ld(pc_ld), .pc_din(pc_din),
    .pc(pc), .ar(ar), .ir(ir), .i_bit(i_bit),
    .dec(dec), .dec_valid(dec_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  int req_cnt = 0;
  bit chk_en = 0;

  logic [DW-1:0] mem [0:4095];

  logic [AW-1:0] m_pc, m_ar;
  logic [DW-1:0] m_ir;
  logic          m_ib, m_busy, m_req, m_dv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [7:0] e_dec;
      e_dec = m_dv ? (8'd1 << m_ir[14:12]) : 8'd0;
      chk("pc", {20'd0, pc}, {20'd0, m_pc});
      chk("ar", {20'd0, ar}, {20'd0, m_ar});
      chk("mem_addr", {20'd0, mem_addr}, {20'd0, m_ar});
      chk("ir", {16'd0, ir}, {16'd0, m_ir});
      chk("i_bit", {31'd0, i_bit}, {31'd0, m_ib});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
      chk("dec_valid", {31'd0, dec_valid}, {31'd0, m_dv});
      chk("dec", {24'd0, dec}, {24'd0, e_dec});
      if (mem_req) req_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  // Inputs that must have no effect in the current phase get random values.
  task automatic noise();
    mem_rdata    = DW'($urandom);
    mem_rd_valid = 1'($urandom);
    pc_din       = AW'($urandom);
    pc_ld        = 1'($urandom);
    halt         = 1'($urandom);
    exec_done    = 1'b0;
    start        = m_busy ? 1'($urandom) : 1'b0;
  endtask

  task automatic model_reset();
    m_pc = '0; m_ar = '0; m_ir = '0; m_ib = 0;
    m_busy = 0; m_req = 0; m_dv = 0;
  endtask

  task automatic do_reset();
    noise();
    rst = 1'b1;
    tick();
    model_reset();
    rst = 1'b0;
  endtask

  task automatic start_fetch();
    noise();
    start = 1'b1;
    tick();
    m_busy = 1;
  endtask

  // From T0 through to the decode cycle; ar_t1 is AR seen in the first T1 cycle.
  task automatic fetch(input int w1, input int w2, output logic [AW-1:0] ar_t1);
    logic [DW-1:0] d;
    noise();
    tick();
    m_ar = m_pc;
    m_req = 1;
    ar_t1 = ar;
    repeat (w1) begin
      noise(); mem_rd_valid = 1'b0; tick();
    end
    noise();
    d = mem[m_ar];
    mem_rd_valid = 1'b1;
    mem_rdata = d;
    tick();
    m_ir = d;
    m_pc = m_pc + 1'b1;
    m_req = 0;
    noise();
    tick();
    m_ib = m_ir[15];
    m_ar = m_ir[11:0];
    if (m_ib && m_ir[14:12] != 3'b111) begin
      m_req = 1;
      repeat (w2) begin
        noise(); mem_rd_valid = 1'b0; tick();
      end
      noise();
      d = mem[m_ar];
      mem_rd_valid = 1'b1;
      mem_rdata = d;
      tick();
      m_ar = d[11:0];
      m_req = 0;
    end
    m_dv = 1;
  endtask

  task automatic finish(input int ed, input bit ld,
                        input logic [AW-1:0] din, input bit h);
    repeat (ed) begin
      noise(); tick();
    end
    noise();
    exec_done = 1'b1;
    pc_ld = ld;
    pc_din = din;
    halt = h;
    tick();
    exec_done = 1'b0;
    if (ld) m_pc = din;
    m_dv = 0;
    if (h) m_busy = 0;
  endtask

  task automatic set_pc(input logic [AW-1:0] a);
    logic [AW-1:0] x;
    start_fetch();
    fetch(0, 0, x);
    finish(0, 1, a, 1);
  endtask

  initial begin
    int t0;
    logic [AW-1:0] a1;
    bit h;
    rst = 1'b0;
    m_busy = 0;
    noise();
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    mem[12'h005] = 16'h2123;
    mem[12'h000] = 16'h8010;
    mem[12'h010] = 16'h0ABC;
    mem[12'h001] = 16'hF010;
    mem[12'h002] = 16'h3456;
    mem[12'hFFF] = 16'h1000;

    do_reset();
    chk_en = 1;
    chk("lit_reset_busy", {31'd0, busy}, 32'd0);
    chk("lit_reset_pc", {20'd0, pc}, 32'd0);

    // direct fetch at 0x005
    set_pc(12'h005);
    t0 = ticks;
    start_fetch();
    chk("lit_busy_after_start", {31'd0, busy}, 32'd1);
    fetch(0, 0, a1);
    chk("lit_direct_latency", ticks - t0, 32'd4);
    chk("lit_direct_ir", {16'd0, ir}, 32'h2123);
    chk("lit_direct_pc", {20'd0, pc}, 32'h006);
    chk("lit_direct_ar", {20'd0, ar}, 32'h123);
    chk("lit_direct_dec", {24'd0, dec}, 32'h04);
    finish(1, 0, 0, 1);
    chk("lit_halt_busy", {31'd0, busy}, 32'd0);

    // indirect fetch at 0x000
    set_pc(12'h000);
    t0 = ticks;
    start_fetch();
    fetch(0, 0, a1);
    chk("lit_ind_latency", ticks - t0, 32'd5);
    chk("lit_ind_ibit", {31'd0, i_bit}, 32'd1);
    chk("lit_ind_ar", {20'd0, ar}, 32'hABC);
    chk("lit_ind_dec", {24'd0, dec}, 32'h01);
    finish(0, 0, 0, 1);

    // opcode 111 with I set skips the indirect read
    t0 = ticks;
    start_fetch();
    fetch(0, 0, a1);
    chk("lit_skip_latency", ticks - t0, 32'd4);
    chk("lit_skip_ar", {20'd0, ar}, 32'h010);
    chk("lit_skip_dec", {24'd0, dec}, 32'h80);
    finish(0, 0, 0, 1);

    // three wait states at 0x002
    start_fetch();
    req_cnt = 0;
    fetch(3, 0, a1);
    chk("lit_wait_req_cycles", req_cnt, 32'd4);
    chk("lit_wait_ir", {16'd0, ir}, 32'h3456);
    finish(0, 0, 0, 1);

    // PC wrap then branch
    set_pc(12'hFFF);
    start_fetch();
    fetch(0, 0, a1);
    chk("lit_wrap_pc", {20'd0, pc}, 32'h000);
    finish(2, 1, 12'h200, 0);
    fetch(0, 0, a1);
    chk("lit_branch_ar", {20'd0, a1}, 32'h200);
    finish(0, 0, 0, 1);

    // reset in the second T1 cycle, late valid afterwards
    start_fetch();
    noise(); tick();
    m_ar = m_pc; m_req = 1;
    noise(); mem_rd_valid = 1'b0; tick();
    noise(); mem_rd_valid = 1'b0; rst = 1'b1; tick();
    model_reset();
    rst = 1'b0;
    noise(); mem_rd_valid = 1'b1; mem_rdata = 16'hBEEF; tick();
    chk("lit_rst_ir", {16'd0, ir}, 32'd0);
    chk("lit_rst_pc", {20'd0, pc}, 32'd0);
    chk("lit_rst_req", {31'd0, mem_req}, 32'd0);
    chk("lit_rst_busy", {31'd0, busy}, 32'd0);

    // random programs
    repeat (150) begin
      if ($urandom_range(0, 2) == 0) begin
        noise(); tick();
      end
      start_fetch();
      do begin
        fetch($urandom_range(0, 3), $urandom_range(0, 3), a1);
        h = ($urandom_range(0, 3) == 0);
        finish($urandom_range(0, 3), 1'($urandom), AW'($urandom), h);
      end while (!h);
    end

    noise(); tick();
    #2;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, shall set the instruction/memory word width.
REQ-002 Parameter ADDR_W, default 12, shall set the PC/AR width and the address field IR[ADDR_W-1:0].
REQ-003 Parameter OPC_W, default 3, shall set the opcode field IR[ADDR_W+OPC_W-1:ADDR_W]; DATA_W >= ADDR_W+OPC_W+1 is required.
REQ-004 Parameter RESET_PC, default 0, shall set the PC value loaded on reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  leaves IDLE and begins fetching at the current PC.
REQ-008 halt  in  1  sampled at end of DEC; 1 returns to IDLE instead of T0.
REQ-009 mem_req  out  1  read request to instruction memory.
REQ-010 mem_addr  out  ADDR_W  read address; always equals AR.
REQ-011 mem_rd_valid  in  1  memory read-data-valid strobe.
REQ-012 mem_rdata  in  DATA_W  memory read data; valid when mem_rd_valid=1.
REQ-013 exec_done  in  1  execute unit has finished the decoded instruction.
REQ-014 pc_ld  in  1  branch request; only honoured together with exec_done in DEC.
REQ-015 pc_din  in  ADDR_W  branch target.
REQ-016 pc, ar  out  ADDR_W each  program counter and address register.
REQ-017 ir  out  DATA_W  instruction register.
REQ-018 i_bit  out  1  indirect flag, IR[DATA_W-1] latched in T2.
REQ-019 dec  out  2**OPC_W  one-hot opcode decode, valid only while dec_valid=1.
REQ-020 dec_valid  out  1  high only in DEC.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states shall be IDLE, T0, T1, T2, IND, DEC.
REQ-023 IDLE: hold all registers; start=1 -> T0 next cycle.
REQ-024 T0: AR <= PC; -> T1.
REQ-025 T1: mem_req=1; on the cycle mem_rd_valid=1: IR <= mem_rdata, PC <= PC+1 (mod 2**ADDR_W, wrap all-ones -> 0), -> T2; otherwise remain in T1.
REQ-026 T2: i_bit <= IR[DATA_W-1], AR <= IR[ADDR_W-1:0]; if IR[DATA_W-1]=1 and opcode != all-ones -> IND, else -> DEC.
REQ-027 IND: mem_req=1; on mem_rd_valid=1: AR <= mem_rdata[ADDR_W-1:0], -> DEC; otherwise remain in IND.
REQ-028 DEC: dec_valid=1, dec = one-hot of IR opcode field; wait for exec_done=1.
REQ-029 DEC with exec_done=1: if pc_ld=1 then PC <= pc_din; next state IDLE if halt=1, else T0.
REQ-030 pc_ld outside DEC, or in DEC without exec_done, shall have no effect.
REQ-031 mem_req shall be registered: high from the first cycle in T1/IND through the cycle mem_rd_valid is seen, low the following cycle; mem_addr stable throughout.
REQ-032 mem_rd_valid outside T1/IND shall be ignored (no register changes).
REQ-033 Fetch latency with zero-wait memory (mem_rd_valid in first T1 cycle): start to dec_valid = 4 cycles direct, 5 cycles indirect.
REQ-034 start while busy=1 shall be ignored.

Reset
REQ-035 rst=1 shall, at the next rising edge and with priority over all inputs, set state=IDLE, PC=RESET_PC, AR=0, IR=0, i_bit=0, mem_req=0, dec_valid=0, dec=0, busy=0.
REQ-036 rst during T1 or IND shall abandon the read; a late mem_rd_valid after reset shall not modify IR, AR or PC.

Verification
REQ-037 Direct fetch: PC=0x005, M[5]=0x2123, zero-wait -> IR=0x2123, PC=0x006, AR=0x123, i_bit=0, dec=8'b0000_0100, dec_valid 4 cycles after start.
REQ-038 Indirect fetch: M[0]=0x8010, M[0x010]=0x0ABC -> i_bit=1, AR=0xABC in DEC, dec=8'b0000_0001; IR=0xF010 instead skips IND (opcode 111).
REQ-039 Wait states: mem_rd_valid delayed 3 cycles in T1 -> mem_req high 4 cycles, mem_addr constant, IR captured only on valid cycle.
REQ-040 PC wrap and branch: PC=0xFFF fetch -> PC=0x000; in DEC exec_done=1, pc_ld=1, pc_din=0x200 -> next T0 gives AR=0x200.
REQ-041 Reset mid-read: rst in second T1 cycle, mem_rd_valid one cycle later -> IDLE, PC=RESET_PC, IR=0, mem_req=0.
REQ-042 Halt/start: halt=1 with exec_done -> busy=0 next cycle; start while busy -> no state change.
